// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore fetch/decode/execute control unit driving the Mini-SRC datapath strobes
module control_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        stop,
  output logic        PCout,
  output logic        ZHighout,
  output logic        ZLowout,
  output logic        MDRout,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        MARin,
  output logic        MDRin,
  output logic        PCin,
  output logic        IRin,
  output logic        Yin,
  output logic        ZHighIn,
  output logic        ZLowIn,
  output logic        Rin,
  output logic        HIin,
  output logic        LOin,
  output logic        CONin,
  output logic        OutPortin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  operation,
  output logic        run,
  output logic [3:0]  state
);
  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_T0    = 4'd1;
  localparam logic [3:0] S_T1    = 4'd2;
  localparam logic [3:0] S_T2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_T7    = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd9;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  logic [4:0] op;
  logic [3:0] nxt;
  logic       unused_ir;
  logic       t0, t1, t2, t3, t4, t5, t6, t7;
  logic       is_ld, is_ldi, is_st, is_mem, is_alu, is_addi, is_halt, uses_reg, short_ex, last;
  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign is_ld     = op == 5'd0;
  assign is_ldi    = op == 5'd1;
  assign is_st     = op == 5'd2;
  assign is_alu    = op >= 5'd3 && op <= 5'd6;
  assign is_addi   = op == 5'd12;
  assign is_halt   = op == 5'd27;
  assign is_mem    = is_ld || is_ldi || is_st;
  assign uses_reg  = is_mem || is_alu || is_addi;
  assign short_ex  = is_ldi || is_alu || is_addi;
  assign t0 = state == S_T0;
  assign t1 = state == S_T1;
  assign t2 = state == S_T2;
  assign t3 = state == S_T3;
  assign t4 = state == S_T4;
  assign t5 = state == S_T5;
  assign t6 = state == S_T6;
  assign t7 = state == S_T7;
  assign last = (t2 && !(uses_reg || is_halt)) || (t5 && short_ex) || t7;
  always_comb
    nxt = state == S_RESET ? S_T0 :
          state == S_HALT  ? S_HALT :
          state >  S_HALT  ? S_RESET :
          last             ? (stop ? S_HALT : S_T0) :
          (t3 && is_halt)  ? S_HALT : state + 4'd1;
  always_ff @(posedge clk or posedge clr)
    if (clr) state <= S_RESET;
    else     state <= nxt;
  assign PCout     = t0;
  assign ZHighout  = 1'b0;
  assign ZLowout   = t1 || (t5 && uses_reg);
  assign MDRout    = t2 || (t7 && is_ld);
  assign Rout      = (t3 && (is_alu || is_addi)) || (t4 && is_alu) || (t6 && is_st);
  assign BAout     = t3 && is_mem;
  assign Cout      = t4 && (is_mem || is_addi);
  assign HIout     = 1'b0;
  assign LOout     = 1'b0;
  assign InPortout = 1'b0;
  assign MARin     = t0 || (t5 && (is_ld || is_st));
  assign MDRin     = t1 || (t6 && (is_ld || is_st));
  assign PCin      = t1;
  assign IRin      = t2;
  assign Yin       = t3 && uses_reg;
  assign ZHighIn   = t0 || (t4 && uses_reg);
  assign ZLowIn    = t0 || (t4 && uses_reg);
  assign Rin       = (t5 && short_ex) || (t7 && is_ld);
  assign HIin      = 1'b0;
  assign LOin      = 1'b0;
  assign CONin     = 1'b0;
  assign OutPortin = 1'b0;
  assign Gra       = (t5 && short_ex) || (t6 && is_st) || (t7 && is_ld);
  assign Grb       = t3 && uses_reg;
  assign Grc       = t4 && is_alu;
  assign IncPC     = t0;
  assign Read      = t1 || (t6 && is_ld);
  assign Write     = t7 && is_st;
  assign operation = (t4 && (is_mem || is_addi)) ? OP_ADD : (t4 && is_alu) ? op : 5'd0;
  assign run       = state >= S_T0 && state <= S_T7;
endmodule
